alu_shift_rcx: RTL and testbench
================================

// Module: alu_shift_rcx
// PURPOSE
//  Multi-clock rotate-through-carry unit (RCL/RCR) on the alternate data path of the shift ALU.
//  The scheduler issues an op with dataEn=1 and nDataAlt=0. The shift ALU then suppresses its own result.
//  This block iterates one bit per cycle and returns the result and COASZP flags on the shared valRes/retData buses.
//  It can be flushed by a thread-matched exception.
// PARAMETERS
//  EXCEPT_WIDTH   9    width of the retData bus; flags occupy `except_flags.
//  CNT_WIDTH      6    width of the iteration counter.
// PORTS
//  clk            in   1   clock, posedge.
//  rst            in   1   asynchronous reset, active-low.
//  except         in   1   pipeline flush request.
//  except_thread  in   1   thread being flushed.
//  thread         in   1   thread of the issuing op, sampled at start.
//  start          in   1   issue strobe: dataEn & ~nDataAlt & rotate-through-carry op.
//  dir            in   1   1=RCR, 0=RCL.
//  sz             in   4   operand size mask: [3]=64, [2]=32, [1]=16, [0]=8. Exactly one bit is set.
//  carry_in       in   1   CF input.
//  val1           in   64  operand; bits above the size are ignored and returned as zero.
//  count          in   6   raw rotate count.
//  busy           out  1   op in flight; the scheduler must not issue while it is high.
//  done           out  1   one-cycle result-valid pulse.
//  valRes         out  64  result; driven only while done=1, otherwise 64'bz.
//  retData        out  EXCEPT_WIDTH  flags {C,O,A,S,Z,P} on `except_flags while done=1, otherwise z.
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, all datapath registers 0; buses float.
//  Count normalisation, computed at start:
//   - 64-bit: n = count[5:0].
//   - 32-bit: n = count[4:0].
//   - 16-bit: n = count[4:0] mod 17.
//   - 8-bit:  n = count[4:0] mod 9.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE + start: latch the masked operand, carry, dir, sz, thread and n; busy=1.
//     If n=0, go to DONE; otherwise go to RUN.
//   - RUN, each cycle: rotate {C,val} by one bit within the size and decrement n.
//     RCL: C' = msb, val' = {val<<1 | C}.
//     RCR: C' = lsb, val' = {C, val>>1}.
//     On the cycle the counter reaches 0, go to DONE.
//   - DONE: done=1 for exactly one cycle; buses driven; then go to IDLE with busy=0.
//  Latency: start to done is n+1 cycles; n=0 gives done on the cycle after start.
//  Throughput: one op per n+2 cycles; busy is high from the cycle after start through DONE.
//  Flags, computed on the final value r at width w:
//   - C = final carry.
//   - O is defined only when the original n = 1, else 0:
//     RCL: r[w-1]^C.
//     RCR: r[w-1]^r[w-2].
//   - A = 0.
//   - S = r[w-1].
//   - Z = (r[w-1:0] == 0).
//   - P = ~^r[7:0].
//  n=0: result = masked operand, C = carry_in, O = 0.
//  Flush: except && except_thread == latched thread while in RUN or DONE
//   - Next state is IDLE; done is forced to 0 in that cycle; no result is emitted.
//  Flush with a non-matching thread: no effect.
//  start and a matching flush (except_thread == thread) in the same cycle from IDLE: start is dropped.
//  start while busy=1: ignored. This is an illegal-issue assertion in simulation.
//  Reset asserted mid-operation: immediate return to IDLE; done=0 and buses float asynchronously.
// TESTING
//  1. RCL 8-bit, val1=0x81, carry_in=0, count=1 -> done 2 cycles after start.
//     valRes=0x02, C=1, O=1, Z=0, P=0.
//  2. RCR 64-bit, val1=1, carry_in=1, count=1 -> valRes=0x8000_0000_0000_0000.
//     C=1, O=1, S=1.
//  3. RCL 16-bit, count=17 -> n=0; valRes=val1 unchanged, C=carry_in, done 1 cycle after start.
//  4. RCL 32-bit, count=33 -> n=1 (count[4:0]); start-to-done latency is 2 cycles.
//  5. RCR 64-bit, count=40, flush with a matching thread at cycle 10 -> no done pulse.
//     busy drops next cycle; a new start is accepted immediately after.
//  6. Same as 5 with a non-matching thread -> done at cycle 41.
//     Also assert rst low mid-RUN -> busy=0, done=0 and buses z at once.

Source files
------------

// File: rtl/alu_shift_rcx_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_rcx_if
// Description : Issue/result bundle between the scheduler and the
//               rotate-through-carry unit, including the shared result buses.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_shift_rcx_if #(
    parameter int EXCEPT_WIDTH = 9
);
    logic                    except;
    logic                    except_thread;
    logic                    thread;
    logic                    start;
    logic                    dir;
    logic [3:0]              sz;
    logic                    carry_in;
    logic [63:0]             val1;
    logic [5:0]              count;
    logic                    busy;
    logic                    done;
    // Shared buses: other units drive them when this block floats them.
    wire  [63:0]             valRes;
    wire  [EXCEPT_WIDTH-1:0] retData;

    modport master (
        output except, except_thread, thread, start, dir, sz, carry_in, val1, count,
        input  busy, done, valRes, retData
    );

    modport slave (
        input  except, except_thread, thread, start, dir, sz, carry_in, val1, count,
        output busy, done, valRes, retData
    );
endinterface
`default_nettype wire

// File: rtl/alu_shift_rcx.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_rcx
// Description : Multi-cycle RCL/RCR unit. It rotates {C,val} one bit per
//               cycle within the operand size and returns the result and
//               the COASZP flags on the shared buses for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_rcx #(
    parameter int EXCEPT_WIDTH = 9,
    parameter int CNT_WIDTH    = 6
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_shift_rcx_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [63:0]            r_val;
    logic                   r_c;
    logic                   r_dir;
    logic [3:0]             r_sz;
    logic                   r_thread;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_n_one;

    logic [4:0]             w_c5;
    logic [CNT_WIDTH-1:0]   w_n;
    logic [63:0]            w_in_mask;
    logic [63:0]            w_mask;
    logic [63:0]            w_top;
    logic                   w_msb;
    logic                   w_msb2;
    logic [63:0]            w_rot_val;
    logic                   w_rot_c;
    logic                   w_accept;
    logic                   w_flush;
    logic                   w_done;
    logic                   w_flag_o;
    logic [5:0]             w_flags;

    // Operand width mask for a one-hot size selector.
    function automatic logic [63:0] f_mask(input logic [3:0] s);
        logic [63:0] m;
        m = 64'h0000_0000_0000_00FF;
        if (s[3])      m = 64'hFFFF_FFFF_FFFF_FFFF;
        else if (s[2]) m = 64'h0000_0000_FFFF_FFFF;
        else if (s[1]) m = 64'h0000_0000_0000_FFFF;
        return m;
    endfunction

    assign w_c5      = bus.count[4:0];
    assign w_in_mask = f_mask(bus.sz);
    assign w_mask    = f_mask(r_sz);
    assign w_top     = w_mask & ~(w_mask >> 1);
    assign w_msb     = |(r_val & w_top);
    assign w_msb2    = |(r_val & (w_top >> 1));

    // A start from the same thread being flushed this cycle never enters.
    assign w_accept  = bus.start && !(bus.except && (bus.except_thread == bus.thread));
    assign w_flush   = bus.except && (bus.except_thread == r_thread) && (r_state != S_IDLE);
    assign w_done    = (r_state == S_DONE) && !w_flush;

    // Rotate count reduced modulo (width+1) for the narrow sizes.
    always_comb begin
        w_n = '0;
        if (bus.sz[3])      w_n = CNT_WIDTH'(bus.count);
        else if (bus.sz[2]) w_n = CNT_WIDTH'(w_c5);
        else if (bus.sz[1]) w_n = CNT_WIDTH'((w_c5 >= 5'd17) ? (w_c5 - 5'd17) : w_c5);
        else                w_n = CNT_WIDTH'(w_c5 % 5'd9);
    end

    // One-bit rotation of {C,val} within the latched operand size.
    always_comb begin
        w_rot_val = r_val;
        w_rot_c   = r_c;
        if (!r_dir) begin
            w_rot_c   = w_msb;
            w_rot_val = ((r_val << 1) | {63'b0, r_c}) & w_mask;
        end else begin
            w_rot_c   = r_val[0];
            w_rot_val = (r_val >> 1) | (r_c ? w_top : 64'b0);
        end
    end

    // Overflow is only architecturally defined for a single-bit rotate.
    always_comb begin
        w_flag_o = 1'b0;
        if (r_n_one) w_flag_o = r_dir ? (w_msb ^ w_msb2) : (w_msb ^ r_c);
    end

    assign w_flags = {r_c, w_flag_o, 1'b0, w_msb, (r_val == 64'b0), ~^r_val[7:0]};

    // Next-state selection; a matching flush always returns to idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = (w_n == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (w_flush)                         w_state_nxt = S_IDLE;
                else if (r_cnt == CNT_WIDTH'(1))     w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Operand capture at issue and per-cycle rotation while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_val    <= '0;
            r_c      <= 1'b0;
            r_dir    <= 1'b0;
            r_sz     <= '0;
            r_thread <= 1'b0;
            r_cnt    <= '0;
            r_n_one  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_val    <= bus.val1 & w_in_mask;
                r_c      <= bus.carry_in;
                r_dir    <= bus.dir;
                r_sz     <= bus.sz;
                r_thread <= bus.thread;
                r_cnt    <= w_n;
                r_n_one  <= (w_n == CNT_WIDTH'(1));
            end
        end else if ((r_state == S_RUN) && !w_flush) begin
            r_val <= w_rot_val;
            r_c   <= w_rot_c;
            r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = w_done;
    assign bus.valRes  = w_done ? r_val : {64{1'bz}};
    assign bus.retData = w_done ? EXCEPT_WIDTH'(w_flags) : {EXCEPT_WIDTH{1'bz}};

    // The scheduler must hold off while an op is in flight.
    a_illegal_issue: assert property (@(posedge clk) disable iff (!rst) !(bus.start && bus.busy));

endmodule
`default_nettype wire

// File: tb/tb_alu_shift_rcx.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_shift_rcx
// Description : Self-checking bench for alu_shift_rcx against a rotate-by-n
//               reference model of the (width+1)-bit {C,val} register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_shift_rcx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_shift_rcx_if #(.EXCEPT_WIDTH(9)) bus ();

    alu_shift_rcx #(.EXCEPT_WIDTH(9), .CNT_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: rotate the (w+1)-bit value {C,val} by n as a whole.
    function automatic void model(input logic d, input logic [3:0] s, input logic ci,
                                  input logic [63:0] v, input logic [5:0] cnt,
                                  output int n, output logic [63:0] r, output logic [8:0] fl);
        int w;
        int c5;
        logic [127:0] x, m, vm;
        logic c, o;
        w  = s[3] ? 64 : s[2] ? 32 : s[1] ? 16 : 8;
        c5 = int'(cnt[4:0]);
        if (w == 64)      n = int'(cnt);
        else if (w == 32) n = c5;
        else if (w == 16) n = c5 % 17;
        else              n = c5 % 9;
        m  = (128'd1 << (w + 1)) - 128'd1;
        vm = (128'd1 << w) - 128'd1;
        x  = ({64'b0, v} & vm) | ({127'b0, ci} << w);
        if (n > 0) begin
            if (!d) x = ((x << n) | (x >> (w + 1 - n))) & m;
            else    x = ((x >> n) | (x << (w + 1 - n))) & m;
        end
        c = x[w];
        r = x[63:0] & vm[63:0];
        o = 1'b0;
        if (n == 1) o = d ? (r[w-1] ^ r[w-2]) : (r[w-1] ^ c);
        fl = {3'b0, c, o, 1'b0, r[w-1], (r == 64'b0), ~^r[7:0]};
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0; bus.except = 1'b0; bus.except_thread = 1'b0; bus.thread = 1'b0;
        bus.dir = 1'b0; bus.sz = 4'b0001; bus.carry_in = 1'b0; bus.val1 = '0; bus.count = '0;
    endtask

    // Drive start for one cycle; returns at the negedge of the following cycle.
    task automatic issue(input logic d, input logic [3:0] s, input logic ci,
                         input logic [63:0] v, input logic [5:0] cnt, input logic th);
        bus.dir = d; bus.sz = s; bus.carry_in = ci; bus.val1 = v; bus.count = cnt;
        bus.thread = th; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Latency counted in cycles after the start cycle; the caller is one cycle in.
    task automatic wait_done(input int max, inout int lat, output logic found);
        while (!bus.done && lat < max) begin
            @(negedge clk);
            lat++;
        end
        found = bus.done;
    endtask

    task automatic check_result(input string tag, input int lat, input logic found,
                                input int n, input logic [63:0] r, input logic [8:0] fl);
        check({tag, " done seen"}, 128'(found), 128'd1);
        if (found) begin
            check({tag, " latency"}, 128'(lat), 128'(n + 1));
            check({tag, " valRes"},  128'(bus.valRes), 128'(r));
            check({tag, " flags"},   128'(bus.retData), 128'(fl));
        end
        @(negedge clk);
        check({tag, " busy after"}, 128'(bus.busy), 128'd0);
    endtask

    task automatic op_check(input string tag, input logic d, input logic [3:0] s, input logic ci,
                            input logic [63:0] v, input logic [5:0] cnt, input logic th);
        int n, lat;
        logic [63:0] r;
        logic [8:0] fl;
        logic found;
        model(d, s, ci, v, cnt, n, r, fl);
        issue(d, s, ci, v, cnt, th);
        lat = 1;
        wait_done(100, lat, found);
        check_result(tag, lat, found, n, r, fl);
    endtask

    initial begin
        int n, lat;
        logic [63:0] r;
        logic [8:0] fl;
        logic found, seen_done;

        idle_inputs();
        repeat (3) @(negedge clk);
        check("reset busy", 128'(bus.busy), 128'd0);
        check("reset done", 128'(bus.done), 128'd0);
        rst = 1'b1;
        @(negedge clk);

        op_check("t1 rcl8",  1'b0, 4'b0001, 1'b0, 64'h81, 6'd1, 1'b0);
        op_check("t2 rcr64", 1'b1, 4'b1000, 1'b1, 64'h1, 6'd1, 1'b0);
        op_check("t3 rcl16 n0", 1'b0, 4'b0010, 1'b1, 64'hFFFF_0000_0000_ABCD, 6'd17, 1'b1);
        op_check("t4 rcl32", 1'b0, 4'b0100, 1'b0, 64'h1234_5678_C000_0001, 6'd33, 1'b0);
        op_check("rcr8 wrap", 1'b1, 4'b0001, 1'b1, 64'h5A, 6'd31, 1'b1);

        // Matching flush mid-run: no result, idle next cycle.
        issue(1'b1, 4'b1000, 1'b0, 64'hDEAD_BEEF_0123_4567, 6'd40, 1'b1);
        seen_done = 1'b0;
        repeat (9) begin
            seen_done |= bus.done;
            @(negedge clk);
        end
        bus.except = 1'b1; bus.except_thread = 1'b1;
        seen_done |= bus.done;
        @(negedge clk);
        bus.except = 1'b0;
        check("flush busy", 128'(bus.busy), 128'd0);
        check("flush no done", 128'(seen_done | bus.done), 128'd0);
        op_check("after flush", 1'b0, 4'b0001, 1'b1, 64'h3C, 6'd3, 1'b0);

        // Flush of the other thread must not disturb the op.
        model(1'b1, 4'b1000, 1'b0, 64'hDEAD_BEEF_0123_4567, 6'd40, n, r, fl);
        issue(1'b1, 4'b1000, 1'b0, 64'hDEAD_BEEF_0123_4567, 6'd40, 1'b1);
        repeat (9) @(negedge clk);
        bus.except = 1'b1; bus.except_thread = 1'b0;
        @(negedge clk);
        bus.except = 1'b0;
        lat = 11;
        wait_done(100, lat, found);
        check_result("t6 nomatch", lat, found, n, r, fl);

        // Asynchronous reset mid-run.
        issue(1'b0, 4'b1000, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 6'd40, 1'b0);
        repeat (5) @(negedge clk);
        check("pre-reset busy", 128'(bus.busy), 128'd1);
        rst = 1'b0;
        #1;
        check("async rst busy", 128'(bus.busy), 128'd0);
        check("async rst done", 128'(bus.done), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Start together with a flush of its own thread is dropped.
        bus.thread = 1'b1; bus.start = 1'b1; bus.except = 1'b1; bus.except_thread = 1'b1;
        bus.sz = 4'b0001; bus.count = 6'd2;
        @(negedge clk);
        bus.start = 1'b0; bus.except = 1'b0;
        check("dropped start busy", 128'(bus.busy), 128'd0);
        @(negedge clk);
        check("dropped start done", 128'(bus.done), 128'd0);

        // Randomized ops across all sizes, directions and counts.
        for (int i = 0; i < 40; i++) begin
            logic [63:0] v;
            v = {$urandom(), $urandom()};
            op_check("rand", 1'($urandom_range(0, 1)), 4'(4'b0001 << $urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), v, 6'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
